// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Sub-word byte lanes are little-endian: byte 0 is bits 7:0 of the word.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RMW_WR = 2'b01,
    ST_DONE   = 2'b10
  } lsu_state_e;

  // True for accesses that need a read-modify-write to store.
  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  // Halves select on lane[1] only; lane[0] is ignored for them.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        zero_ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = zero_ext ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = zero_ext ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane insert: replaces the addressed byte/half of old_word_i
// with the low bits of new_data_i. Word size passes new_data_i through.
module store_merge
  import lsu_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_word_o
);

  // Overwrite only the target lane, keep the rest of the old word.
  always_comb begin
    merged_word_o = old_word_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merged_word_o[7:0]   = new_data_i[7:0];
          2'd1:    merged_word_o[15:8]  = new_data_i[7:0];
          2'd2:    merged_word_o[23:16] = new_data_i[7:0];
          default: merged_word_o[31:24] = new_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1]) merged_word_o[31:16] = new_data_i[15:0];
        else           merged_word_o[15:0]  = new_data_i[15:0];
      end
      default: merged_word_o = new_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle datapath and a word-only memory.
// Loads and word stores are zero-latency; byte/half stores do a 3-cycle
// read-modify-write and hold the CPU with stall.
// Build option: define MISALIGN_TRAP_EN to flag misaligned accesses (and the
// reserved size) and suppress their memory strobes; otherwise misaligned is 0,
// halves use addr[1], words ignore addr[1:0] and size 11 acts as word.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | accept requests; loads/word stores complete this cycle
//   ST_RMW_WR | write merged word to the latched address, CPU still held
//   ST_DONE   | no strobes, stall released; CPU advances, requests ignored
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [31:0]       merge_buf_q, merge_buf_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;

  logic              req;
  logic              mis_det;
  logic [1:0]        eff_size;
  logic [31:0]       merged_word;

  assign req      = MemRead | MemWrite;
  // Reserved size only reaches the datapath in the non-trapping build.
  assign eff_size = (size == SZ_RSVD) ? SZ_WORD : size;

`ifdef MISALIGN_TRAP_EN
  // Natural-alignment check, only meaningful when a request is present.
  always_comb begin
    mis_det = 1'b0;
    if (req) begin
      case (size)
        SZ_HALF: mis_det = addr[0];
        SZ_WORD: mis_det = |addr[1:0];
        SZ_RSVD: mis_det = 1'b1;
        default: mis_det = 1'b0;
      endcase
    end
  end
`else
  assign mis_det = 1'b0;
`endif

  store_merge u_store_merge (
    .old_word_i    (mem_rdata),
    .new_data_i    (store_data),
    .size_i        (eff_size),
    .lane_i        (addr[1:0]),
    .merged_word_o (merged_word)
  );

  // State, merge buffer and latched word address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      merge_buf_q <= '0;
      waddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      merge_buf_q <= merge_buf_d;
      waddr_q     <= waddr_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    merge_buf_d = merge_buf_q;
    waddr_d     = waddr_q;
    stall       = 1'b0;
    misaligned  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = store_data;
    mem_addr    = {addr[ADDR_W-1:2], 2'b00};
    load_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (!reset) begin
          misaligned = mis_det;
          if (!mis_det) begin
            if (MemWrite) begin
              if (is_subword(eff_size)) begin
                mem_read    = 1'b1;
                stall       = 1'b1;
                merge_buf_d = merged_word;
                waddr_d     = addr[ADDR_W-1:2];
                state_d     = ST_RMW_WR;
              end else begin
                mem_write = 1'b1;
              end
            end else if (MemRead) begin
              mem_read  = 1'b1;
              load_data = lane_extract(mem_rdata, eff_size, addr[1:0], is_unsigned);
            end
          end
        end
      end
      ST_RMW_WR: begin
        // The write goes out even if reset arrives in this cycle, so a
        // store that already read its word is never lost half-way.
        mem_write = 1'b1;
        mem_wdata = merge_buf_q;
        mem_addr  = {waddr_q, 2'b00};
        stall     = !reset;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// aligned loads/stores against a word-array reference memory.
module tb_load_store_unit;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, is_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, store_data;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic        stall, misaligned, mem_read, mem_write;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  int          n_writes = 0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .size(size), .is_unsigned(is_unsigned), .addr(addr),
    .store_data(store_data), .load_data(load_data), .stall(stall),
    .misaligned(misaligned), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, write on posedge.
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      n_writes <= n_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; size = W; is_unsigned = 0;
    addr = 0; store_data = 0;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                              input logic uns);
    logic [31:0] w, v;
    w = ref_mem[a[5:2]];
    if (sz == B) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == H) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == B) begin
      sh = 8 * a[1:0]; mask = 32'hFF << sh;
      return (w & ~mask) | ((d & 32'hFF) << sh);
    end else if (sz == H) begin
      sh = 16 * a[1]; mask = 32'hFFFF << sh;
      return (w & ~mask) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    MemRead = 1; MemWrite = 0; size = sz; addr = a; is_unsigned = uns;
    @(negedge clk);
    check("ld_data", load_data, model_load(a, sz, uns));
    check("ld_stall", {31'b0, stall}, 0);
    check("ld_mem_read", {31'b0, mem_read}, 1);
    check("ld_mem_addr", mem_addr, a & ~32'h3);
    tick();
    idle_inputs();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int pre;
    logic [31:0] exp_w;
    pre = n_writes;
    exp_w = model_store(ref_mem[a[5:2]], a, sz, d);
    MemRead = 0; MemWrite = 1; size = sz; addr = a; store_data = d;
    @(negedge clk);
    if (sz == W) begin
      check("sw_mem_write", {31'b0, mem_write}, 1);
      check("sw_stall", {31'b0, stall}, 0);
      check("sw_wdata", mem_wdata, d);
      check("sw_mem_addr", mem_addr, a & ~32'h3);
      tick();
    end else begin
      check("sub_c1_stall", {31'b0, stall}, 1);
      check("sub_c1_read", {31'b0, mem_read}, 1);
      check("sub_c1_write", {31'b0, mem_write}, 0);
      tick();
      // Inputs are ignored once the sequence has started.
      addr = $urandom; store_data = $urandom; MemRead = 1'($urandom);
      MemWrite = 1; size = 2'($urandom);
      @(negedge clk);
      check("sub_c2_stall", {31'b0, stall}, 1);
      check("sub_c2_write", {31'b0, mem_write}, 1);
      check("sub_c2_wdata", mem_wdata, exp_w);
      check("sub_c2_addr", mem_addr, a & ~32'h3);
      tick();
      @(negedge clk);
      check("sub_c3_stall", {31'b0, stall}, 0);
      check("sub_c3_strobes", {30'b0, mem_read, mem_write}, 0);
      tick();
    end
    check("store_write_count", n_writes - pre, 1);
    ref_mem[a[5:2]] = exp_w;
    idle_inputs();
  endtask

  initial begin
    int pre;
    logic [31:0] a;
    logic [1:0]  sz;

    idle_inputs();
    reset = 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'h0; ref_mem[1] = 32'hDEADBEEF;
    ref_mem[2] = 32'h8899AABB; ref_mem[4] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      pl_en = 1; pl_idx = 4'(i); pl_data = ref_mem[i];
      tick();
    end
    pl_en = 0;

    // Outputs held quiet during reset even with a request present.
    MemRead = 1; addr = 32'h9; size = B;
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_strobes", {30'b0, mem_read, mem_write}, 0);
    check("rst_load_data", load_data, 0);
    check("rst_misaligned", {31'b0, misaligned}, 0);
    tick();
    reset = 0;
    idle_inputs();
    tick();

    do_load(32'h9, B, 0);
    check("lb_value", model_load(32'h9, B, 0), 32'hFFFFFFAA);
    do_load(32'h9, B, 1);
    do_load(32'hA, H, 0);
    check("lh_value", model_load(32'hA, H, 0), 32'hFFFF8899);
    do_load(32'hA, H, 1);

    do_store(32'h5, B, 32'h12345677);
    check("sb_model", ref_mem[1], 32'hDEAD77EF);
    do_load(32'h4, W, 0);
    do_store(32'h10, W, 32'hCAFEF00D);
    do_load(32'h10, W, 0);

    // No request: strobes off, load_data 0, mem_addr still follows addr.
    addr = 32'h2E; MemRead = 0; MemWrite = 0;
    @(negedge clk);
    check("none_strobes", {29'b0, stall, mem_read, mem_write}, 0);
    check("none_load_data", load_data, 0);
    check("none_mem_addr", mem_addr, 32'h2C);
    tick();

    // Both requests high: a word store, never a load.
    MemRead = 1; MemWrite = 1; size = W; addr = 32'h14; store_data = 32'h0BADF00D;
    @(negedge clk);
    check("both_load_data", load_data, 0);
    check("both_mem_write", {31'b0, mem_write}, 1);
    tick();
    ref_mem[5] = 32'h0BADF00D;
    idle_inputs();

`ifdef MISALIGN_TRAP_EN
    pre = n_writes;
    MemRead = 1; size = H; addr = 32'h3;
    @(negedge clk);
    check("mis_lh_flag", {31'b0, misaligned}, 1);
    check("mis_lh_strobes", {29'b0, stall, mem_read, mem_write}, 0);
    check("mis_lh_data", load_data, 0);
    tick();
    MemRead = 0; MemWrite = 1; size = W; addr = 32'h6; store_data = 32'h55555555;
    @(negedge clk);
    check("mis_sw_flag", {31'b0, misaligned}, 1);
    check("mis_sw_strobes", {29'b0, stall, mem_read, mem_write}, 0);
    tick();
    MemWrite = 1; size = 2'b11; addr = 32'h8;
    @(negedge clk);
    check("mis_rsvd_flag", {31'b0, misaligned}, 1);
    tick();
    idle_inputs();
    check("mis_no_write", n_writes - pre, 0);
    do_load(32'h4, W, 0);
`else
    MemRead = 1; size = H; addr = 32'h3;
    @(negedge clk);
    check("nomis_flag", {31'b0, misaligned}, 0);
    tick();
    do_load(32'h3, H, 0);
`endif

    // Reset in the RMW_WR cycle: the write still lands.
    ref_mem[0] = 32'h0;
    MemWrite = 1; size = H; addr = 32'h2; store_data = 32'h0000BEEF;
    tick();
    reset = 1;
    @(negedge clk);
    check("rstrmw_write", {31'b0, mem_write}, 1);
    check("rstrmw_wdata", mem_wdata, 32'hBEEF0000);
    tick();
    reset = 0;
    idle_inputs();
    @(negedge clk);
    check("rstrmw_next_stall", {31'b0, stall}, 0);
    tick();
    ref_mem[0] = 32'hBEEF0000;
    do_load(32'h0, W, 0);

    // Reset in the first cycle: no write at all.
    pre = n_writes;
    reset = 1; MemWrite = 1; size = H; addr = 32'h2; store_data = 32'h1234;
    @(negedge clk);
    check("rstidle_strobes", {29'b0, stall, mem_read, mem_write}, 0);
    tick();
    reset = 0;
    idle_inputs();
    @(negedge clk);
    check("rstidle_next", {29'b0, stall, mem_read, mem_write}, 0);
    tick();
    check("rstidle_no_write", n_writes - pre, 0);
    do_load(32'h0, W, 0);

    // Random aligned traffic.
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 63));
      if (sz == H) a = a & ~32'h1;
      if (sz == W) a = a & ~32'h3;
      if ($urandom_range(0, 1) == 0) do_load(a, sz, 1'($urandom));
      else do_store(a, sz, $urandom);
    end

    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
